// File: rtl/simplerisc_ex_unit.sv
// simplerisc_ex_unit
// Decode, execute and EX/MA pipeline register for the SimpleRisc 5-stage
// in-order core.
//
// Ports:
//   clk                 single clock, all state updates on the rising edge
//   reset               asynchronous, active-low (0 = reset asserted)
//   of_ir               instruction in OF, decoded combinationally
//   of_ctrl             22-bit decoded control bus for of_ir
//   ex_pc               PC of the instruction in EX
//   ex_branch_target    PC + sext(imm27<<2), computed in OF
//   ex_op_a, ex_op_b    ALU operands
//   ex_op2              store data (rd value)
//   ex_ir, ex_ctrl      instruction and control bus in EX
//   ex_alu_result       combinational ALU result (forwarding tap)
//   branch_taken        EX branch resolves taken
//   branch_pc           redirect target, valid whether or not taken
//   flags_e, flags_gt   flags register, loaded by cmp
//   ma_*                EX/MA latch outputs feeding the memory stage
//
// Branches are predicted not-taken; the flush on a taken branch is handled
// outside this block. A taking instruction still moves into MA, because a
// call needs PC+4 written back.

module simplerisc_ex_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] of_ir,
    output logic [21:0] of_ctrl,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_branch_target,
    input  logic [31:0] ex_op_a,
    input  logic [31:0] ex_op_b,
    input  logic [31:0] ex_op2,
    input  logic [31:0] ex_ir,
    input  logic [21:0] ex_ctrl,
    output logic [31:0] ex_alu_result,
    output logic        branch_taken,
    output logic [31:0] branch_pc,
    output logic        flags_e,
    output logic        flags_gt,
    output logic [31:0] ma_pc,
    output logic [31:0] ma_alu_result,
    output logic [31:0] ma_op2,
    output logic [31:0] ma_ir,
    output logic [21:0] ma_ctrl
);

    // Control bus bit positions
    localparam int C_ST   = 0;
    localparam int C_LD   = 1;
    localparam int C_BEQ  = 2;
    localparam int C_BGT  = 3;
    localparam int C_RET  = 4;
    localparam int C_IMM  = 5;
    localparam int C_WB   = 6;
    localparam int C_UBR  = 7;
    localparam int C_CALL = 8;
    localparam int C_ADD  = 9;
    localparam int C_SUB  = 10;
    localparam int C_CMP  = 11;
    localparam int C_MUL  = 12;
    localparam int C_DIV  = 13;
    localparam int C_MOD  = 14;
    localparam int C_LSL  = 15;
    localparam int C_LSR  = 16;
    localparam int C_ASR  = 17;
    localparam int C_OR   = 18;
    localparam int C_AND  = 19;
    localparam int C_NOT  = 20;
    localparam int C_MOV  = 21;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    logic [4:0]  opcode;
    logic [21:0] dec_ctrl;

    assign opcode = of_ir[31:27];

    // Decoder: nop and undefined opcodes leave the bus all zero, including
    // the immediate bit, so they behave as bubbles downstream.
    always_comb begin
        dec_ctrl = '0;
        case (opcode)
            5'd0:  begin dec_ctrl[C_ADD] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd1:  begin dec_ctrl[C_SUB] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd2:  begin dec_ctrl[C_MUL] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd3:  begin dec_ctrl[C_DIV] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd4:  begin dec_ctrl[C_MOD] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd5:  begin dec_ctrl[C_CMP] = 1'b1; end
            5'd6:  begin dec_ctrl[C_AND] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd7:  begin dec_ctrl[C_OR]  = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd8:  begin dec_ctrl[C_NOT] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd9:  begin dec_ctrl[C_MOV] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd10: begin dec_ctrl[C_LSL] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd11: begin dec_ctrl[C_LSR] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd12: begin dec_ctrl[C_ASR] = 1'b1; dec_ctrl[C_WB] = 1'b1; end
            5'd14: begin
                dec_ctrl[C_LD]  = 1'b1;
                dec_ctrl[C_ADD] = 1'b1;
                dec_ctrl[C_WB]  = 1'b1;
            end
            5'd15: begin dec_ctrl[C_ST] = 1'b1; dec_ctrl[C_ADD] = 1'b1; end
            5'd16: begin dec_ctrl[C_BEQ] = 1'b1; end
            5'd17: begin dec_ctrl[C_BGT] = 1'b1; end
            5'd18: begin dec_ctrl[C_UBR] = 1'b1; end
            5'd19: begin
                dec_ctrl[C_UBR]  = 1'b1;
                dec_ctrl[C_CALL] = 1'b1;
                dec_ctrl[C_WB]   = 1'b1;
            end
            5'd20: begin dec_ctrl[C_UBR] = 1'b1; dec_ctrl[C_RET] = 1'b1; end
            default: dec_ctrl = '0;
        endcase
        if (opcode != 5'd13 && opcode <= 5'd20) begin
            dec_ctrl[C_IMM] = of_ir[26];
        end
        if (!reset) begin
            dec_ctrl = '0;
        end
    end

    assign of_ctrl = dec_ctrl;

    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic        [31:0] quot;
    logic        [31:0] rem;
    logic        [31:0] alu;

    assign sa = ex_op_a;
    assign sb = ex_op_b;

    // Divide and remainder: zero divisor and the INT_MIN / -1 overflow are
    // resolved explicitly so the hardware divider never sees them.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (ex_op_b == '0) begin
            quot = NEG_ONE;
            rem  = ex_op_a;
        end else if (ex_op_a == INT_MIN && ex_op_b == NEG_ONE) begin
            quot = ex_op_a;
            rem  = '0;
        end else begin
            quot = sa / sb;
            rem  = sa % sb;
        end
    end

    // ALU result selection; only one op bit is expected to be set.
    always_comb begin
        alu = '0;
        if (ex_ctrl[C_ADD])      alu = ex_op_a + ex_op_b;
        else if (ex_ctrl[C_SUB]) alu = ex_op_a - ex_op_b;
        else if (ex_ctrl[C_MUL]) alu = ex_op_a * ex_op_b;
        else if (ex_ctrl[C_DIV]) alu = quot;
        else if (ex_ctrl[C_MOD]) alu = rem;
        else if (ex_ctrl[C_LSL]) alu = ex_op_a << ex_op_b[4:0];
        else if (ex_ctrl[C_LSR]) alu = ex_op_a >> ex_op_b[4:0];
        else if (ex_ctrl[C_ASR]) alu = sa >>> ex_op_b[4:0];
        else if (ex_ctrl[C_OR])  alu = ex_op_a | ex_op_b;
        else if (ex_ctrl[C_AND]) alu = ex_op_a & ex_op_b;
        else if (ex_ctrl[C_NOT]) alu = ~ex_op_b;
        else if (ex_ctrl[C_MOV]) alu = ex_op_b;
    end

    assign ex_alu_result = alu;

    // Branch resolution uses the registered flags, so a cmp directly ahead
    // of a conditional branch has already updated them.
    assign branch_taken = ex_ctrl[C_UBR]
                        | (ex_ctrl[C_BEQ] & flags_e)
                        | (ex_ctrl[C_BGT] & flags_gt);
    assign branch_pc    = ex_ctrl[C_RET] ? ex_op_a : ex_branch_target;

    // Flags register and EX/MA latch; the latch has no enable and a zero
    // ma_ctrl after reset acts as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_e       <= 1'b0;
            flags_gt      <= 1'b0;
            ma_pc         <= '0;
            ma_alu_result <= '0;
            ma_op2        <= '0;
            ma_ir         <= '0;
            ma_ctrl       <= '0;
        end else begin
            if (ex_ctrl[C_CMP]) begin
                flags_e  <= (ex_op_a == ex_op_b);
                flags_gt <= (sa > sb);
            end
            ma_pc         <= ex_pc;
            ma_alu_result <= alu;
            ma_op2        <= ex_op2;
            ma_ir         <= ex_ir;
            ma_ctrl       <= ex_ctrl;
        end
    end

endmodule

// File: tb/tb_simplerisc_ex_unit.sv
// tb_simplerisc_ex_unit
// Scoreboard bench for simplerisc_ex_unit. The driver issues one EX
// instruction per clock at the falling edge and pushes the expected
// combinational response and the expected EX/MA latch contents into two
// queues; two monitor processes pop and compare them independently.

module tb_simplerisc_ex_unit;

    logic        clk;
    logic        reset;
    logic [31:0] of_ir;
    logic [21:0] of_ctrl;
    logic [31:0] ex_pc;
    logic [31:0] ex_branch_target;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_op2;
    logic [31:0] ex_ir;
    logic [21:0] ex_ctrl;
    logic [31:0] ex_alu_result;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic        flags_e;
    logic        flags_gt;
    logic [31:0] ma_pc;
    logic [31:0] ma_alu_result;
    logic [31:0] ma_op2;
    logic [31:0] ma_ir;
    logic [21:0] ma_ctrl;

    simplerisc_ex_unit dut (
        .clk              (clk),
        .reset            (reset),
        .of_ir            (of_ir),
        .of_ctrl          (of_ctrl),
        .ex_pc            (ex_pc),
        .ex_branch_target (ex_branch_target),
        .ex_op_a          (ex_op_a),
        .ex_op_b          (ex_op_b),
        .ex_op2           (ex_op2),
        .ex_ir            (ex_ir),
        .ex_ctrl          (ex_ctrl),
        .ex_alu_result    (ex_alu_result),
        .branch_taken     (branch_taken),
        .branch_pc        (branch_pc),
        .flags_e          (flags_e),
        .flags_gt         (flags_gt),
        .ma_pc            (ma_pc),
        .ma_alu_result    (ma_alu_result),
        .ma_op2           (ma_op2),
        .ma_ir            (ma_ir),
        .ma_ctrl          (ma_ctrl)
    );

    typedef struct {
        logic [21:0] of_ctrl;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] bpc;
    } comb_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] op2;
        logic [31:0] ir;
        logic [21:0] ctrl;
        logic        fe;
        logic        fgt;
    } latch_t;

    comb_t  comb_q[$];
    latch_t latch_q[$];

    int checks = 0;
    int errors = 0;

    logic model_fe = 1'b0;
    logic model_gt = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference decoder written as an opcode table.
    function automatic logic [21:0] model_decode(input logic [31:0] ir);
        logic [21:0] c;
        int op;
        c = '0;
        op = int'(ir[31:27]);
        case (op)
            0:  c = (22'd1 << 9)  | (22'd1 << 6);
            1:  c = (22'd1 << 10) | (22'd1 << 6);
            2:  c = (22'd1 << 12) | (22'd1 << 6);
            3:  c = (22'd1 << 13) | (22'd1 << 6);
            4:  c = (22'd1 << 14) | (22'd1 << 6);
            5:  c = (22'd1 << 11);
            6:  c = (22'd1 << 19) | (22'd1 << 6);
            7:  c = (22'd1 << 18) | (22'd1 << 6);
            8:  c = (22'd1 << 20) | (22'd1 << 6);
            9:  c = (22'd1 << 21) | (22'd1 << 6);
            10: c = (22'd1 << 15) | (22'd1 << 6);
            11: c = (22'd1 << 16) | (22'd1 << 6);
            12: c = (22'd1 << 17) | (22'd1 << 6);
            14: c = (22'd1 << 1) | (22'd1 << 9) | (22'd1 << 6);
            15: c = (22'd1 << 0) | (22'd1 << 9);
            16: c = (22'd1 << 2);
            17: c = (22'd1 << 3);
            18: c = (22'd1 << 7);
            19: c = (22'd1 << 7) | (22'd1 << 8) | (22'd1 << 6);
            20: c = (22'd1 << 7) | (22'd1 << 4);
            default: c = '0;
        endcase
        if (op != 13 && op <= 20 && ir[26]) c = c | (22'd1 << 5);
        return c;
    endfunction

    // Reference ALU using plain arithmetic on wide signed integers.
    function automatic logic [31:0] model_alu(input int op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        case (op)
            0, 14, 15: r = sa + sb;
            1:  r = sa - sb;
            2:  r = sa * sb;
            3:  r = (sb == 0) ? -1 : sa / sb;
            4:  r = (sb == 0) ? sa : sa % sb;
            6:  r = sa & sb;
            7:  r = sa | sb;
            8:  r = ~sb;
            9:  r = sb;
            10: r = sa << b[4:0];
            11: r = longint'(a) >> b[4:0];
            12: r = sa >>> b[4:0];
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic apply_stimulus(input int op, input logic imm,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] tgt, input logic [31:0] of_word);
        comb_t  ce;
        latch_t le;
        logic [31:0] ir;
        logic [4:0]  opc;
        logic [25:0] low;
        opc = 5'(op);
        low = 26'($urandom);
        ir  = {opc, imm, low};
        @(negedge clk);
        of_ir            = of_word;
        ex_ir            = ir;
        ex_ctrl          = model_decode(ir);
        ex_op_a          = a;
        ex_op_b          = b;
        ex_branch_target = tgt;
        ex_pc            = $urandom;
        ex_op2           = $urandom;
        ce.of_ctrl = model_decode(of_word);
        ce.alu     = model_alu(op, a, b);
        ce.taken   = (op == 18 || op == 19 || op == 20)
                   || (op == 16 && model_fe) || (op == 17 && model_gt);
        ce.bpc     = (op == 20) ? a : tgt;
        comb_q.push_back(ce);
        if (op == 5) begin
            model_fe = (a == b);
            model_gt = ($signed(a) > $signed(b));
        end
        le.pc   = ex_pc;
        le.alu  = ce.alu;
        le.op2  = ex_op2;
        le.ir   = ir;
        le.ctrl = ex_ctrl;
        le.fe   = model_fe;
        le.fgt  = model_gt;
        latch_q.push_back(le);
    endtask

    task automatic apply_random;
        int op;
        logic [31:0] a;
        logic [31:0] b;
        int sel;
        op  = $urandom_range(0, 31);
        sel = $urandom_range(0, 4);
        a   = $urandom;
        case (sel)
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = a;
            3: b = $urandom_range(1, 40);
            default: b = $urandom;
        endcase
        if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
        apply_stimulus(op, 1'($urandom), a, b, $urandom, $urandom);
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && (comb_q.size() > 0 || latch_q.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (comb_q.size() > 0 || latch_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d/%0d expected=0", comb_q.size(), latch_q.size());
            comb_q.delete();
            latch_q.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_ma_pc"}, ma_pc, 32'h0);
        check_output({tag, "_ma_alu"}, ma_alu_result, 32'h0);
        check_output({tag, "_ma_op2"}, ma_op2, 32'h0);
        check_output({tag, "_ma_ir"}, ma_ir, 32'h0);
        check_output({tag, "_ma_ctrl"}, 32'(ma_ctrl), 32'h0);
        check_output({tag, "_flags_e"}, 32'(flags_e), 32'h0);
        check_output({tag, "_flags_gt"}, 32'(flags_gt), 32'h0);
        check_output({tag, "_of_ctrl"}, 32'(of_ctrl), 32'h0);
    endtask

    // Combinational monitor: checks the instruction driven at this falling edge.
    initial begin
        comb_t e;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                check_output("of_ctrl", 32'(of_ctrl), 32'(e.of_ctrl));
                check_output("alu", ex_alu_result, e.alu);
                check_output("branch_taken", 32'(branch_taken), 32'(e.taken));
                check_output("branch_pc", branch_pc, e.bpc);
            end
        end
    end

    // Latch monitor: checks EX/MA contents just after the capturing edge.
    initial begin
        latch_t e;
        forever begin
            @(posedge clk);
            #1;
            if (latch_q.size() > 0) begin
                e = latch_q.pop_front();
                check_output("ma_pc", ma_pc, e.pc);
                check_output("ma_alu", ma_alu_result, e.alu);
                check_output("ma_op2", ma_op2, e.op2);
                check_output("ma_ir", ma_ir, e.ir);
                check_output("ma_ctrl", 32'(ma_ctrl), 32'(e.ctrl));
                check_output("flags_e", 32'(flags_e), 32'(e.fe));
                check_output("flags_gt", 32'(flags_gt), 32'(e.fgt));
            end
        end
    end

    initial begin
        logic [31:0] w_add;
        logic [31:0] w_ld;
        logic [31:0] w_bad;
        w_add = {5'd0, 1'b0, 26'h0};
        w_ld  = {5'd14, 1'b1, 26'h0123};
        w_bad = {5'd25, 27'h0};

        reset            = 1'b0;
        of_ir            = w_ld;
        ex_pc            = 32'h0;
        ex_branch_target = 32'h0;
        ex_op_a          = 32'h0;
        ex_op_b          = 32'h0;
        ex_op2           = 32'h0;
        ex_ir            = 32'h0;
        ex_ctrl          = '0;

        #12;
        check_reset_state("por");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("dec_ld_imm", 32'(of_ctrl), 32'h0000_0262);

        apply_stimulus(0, 1'b0, 32'd5, 32'd7, 32'h0, w_add);
        apply_stimulus(1, 1'b0, 32'd3, 32'd5, 32'h0, w_ld);
        apply_stimulus(12, 1'b1, 32'h8000_0000, 32'd4, 32'h0, w_bad);
        apply_stimulus(3, 1'b0, 32'd7, 32'd0, 32'h0, w_add);
        apply_stimulus(4, 1'b0, 32'd7, 32'd0, 32'h0, w_add);
        apply_stimulus(3, 1'b0, -32'sd7, 32'd2, 32'h0, w_add);
        apply_stimulus(4, 1'b0, -32'sd7, 32'd2, 32'h0, w_add);
        apply_stimulus(3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, w_add);
        apply_stimulus(4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, w_add);
        apply_stimulus(5, 1'b0, 32'd3, 32'd3, 32'h0, w_add);
        apply_stimulus(16, 1'b0, 32'd0, 32'd0, 32'h40, w_add);
        apply_stimulus(17, 1'b0, 32'd0, 32'd0, 32'h80, w_add);
        apply_stimulus(20, 1'b0, 32'h100, 32'd0, 32'h44, w_add);
        apply_stimulus(19, 1'b1, 32'd0, 32'd0, 32'h2000, w_add);

        for (int i = 0; i < 150; i++) apply_random();

        apply_stimulus(5, 1'b0, 32'd9, 32'd9, 32'h0, w_ld);
        apply_stimulus(0, 1'b0, 32'd5, 32'd7, 32'h0, w_ld);
        drain();

        #1;
        reset = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        #1;
        check_reset_state("midrst_hold");
        @(negedge clk);
        reset    = 1'b1;
        model_fe = 1'b0;
        model_gt = 1'b0;

        apply_stimulus(17, 1'b0, 32'd0, 32'd0, 32'h300, w_add);
        for (int i = 0; i < 150; i++) apply_random();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
